// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the mul/div unit.
// Holds the iterative divider state encoding, default divider sizing and the
// quotient value returned for a divide by zero.
package mdu_pkg;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = 6;

    // A divide by zero answers with an all-ones quotient and the dividend as remainder.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
// Ports:
//   partial_rem  - current partial remainder (always < divisor between steps)
//   dividend_msb - dividend bit shifted into the partial remainder this step
//   divisor      - divisor
//   next_rem     - partial remainder after the step
//   quot_bit     - quotient bit produced by the step
module div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             quot_bit
);

    logic [WIDTH-1:0] low_shifted;
    logic [WIDTH-1:0] trial_low;

    // The shifted remainder is WIDTH+1 bits wide, so the compare uses the full
    // width. The subtraction only needs the low WIDTH bits: whenever it is kept,
    // the true difference is below the divisor and fits in WIDTH bits.
    always_comb begin
        low_shifted = {partial_rem[WIDTH-2:0], dividend_msb};
        trial_low   = low_shifted - divisor;
        quot_bit    = ({partial_rem, dividend_msb} >= {1'b0, divisor});
        next_rem    = quot_bit ? trial_low : low_shifted;
    end

endmodule

// File: rtl/iter_divider.sv
// iter_divider: iterative radix-2 restoring unsigned divider, responder on the
// mul/div top's locked-operand interface.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid            - divide request, held stable while stallreq is high
//   flush               - aborts an operation in progress
//   a, b                - unsigned dividend and divisor
//   stallreq            - pipeline stall request while a request is pending
//   out_valid           - one-cycle pulse, quotient/remainder are valid
//   busy                - block is not idle
//   quotient, remainder - registered results, held until the next completion
module iter_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stallreq,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e       state;
    div_state_e       next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] prem_r;
    logic [WIDTH-1:0] next_rem;
    logic             quot_bit;
    logic             request;
    logic             last_step;

    assign request   = in_valid & ~flush;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem  (prem_r),
        .dividend_msb (dividend_r[WIDTH-1]),
        .divisor      (divisor_r),
        .next_rem     (next_rem),
        .quot_bit     (quot_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state. A zero divisor skips the iterations and goes straight to DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request) begin
                    next_state = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs. stallreq follows the request combinationally in IDLE so the
    // pipeline freezes in the very cycle the divide is issued.
    always_comb begin
        stallreq  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    stallreq  = request;
            CALC:    stallreq  = ~flush;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. Quotient bits shift into the dividend register from the LSB as
    // the dividend bits shift out of the MSB into the partial remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dividend_r <= '0;
            divisor_r  <= '0;
            prem_r     <= '0;
            quotient   <= '0;
            remainder  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (b == '0) begin
                            quotient  <= WIDTH'(DIV_ZERO_QUOTIENT);
                            remainder <= a;
                        end else begin
                            dividend_r <= a;
                            divisor_r  <= b;
                            prem_r     <= '0;
                            cnt        <= '0;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        dividend_r <= {dividend_r[WIDTH-2:0], quot_bit};
                        prem_r     <= next_rem;
                        cnt        <= cnt + 1'b1;
                        if (last_step) begin
                            quotient  <= {dividend_r[WIDTH-2:0], quot_bit};
                            remainder <= next_rem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Iterative radix-2 restoring unsigned divider.
- It is the responder on the mul/div top's locked-operand interface. The top drives sign-corrected, width-extended operands plus a held `in_valid`; this block answers with `stallreq` while it computes, then presents the quotient and remainder.
- All sign handling and result selection stay in the mul/div top. This block is purely unsigned.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  divide request; held high and stable by the requester while `stallreq`=1
- flush  input  1  pipeline flush; aborts any operation in progress
- a  input  WIDTH  dividend (unsigned)
- b  input  WIDTH  divisor (unsigned)
- stallreq  output  1  pipeline stall request
- out_valid  output  1  one-cycle pulse; `quotient`/`remainder` are valid
- busy  output  1  state != IDLE
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, counter=0, internal dividend/divisor/partial-remainder registers=0.
  - quotient=0, remainder=0, out_valid=0, busy=0, stallreq=0.
  - Reset asserted mid-operation discards the operation immediately; no out_valid follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - stallreq = in_valid & ~flush (combinational, same cycle), so the pipeline freezes in the request cycle.
  - in_valid & ~flush & b!=0: capture a, b; partial remainder=0; counter=0; next state CALC.
  - in_valid & ~flush & b==0: quotient<=all ones, remainder<=a; next state DONE. stallreq is high for exactly 1 cycle.
- CALC:
  - stallreq=1.
  - Each cycle runs one restoring step:
    - shift {partial_rem, dividend} left by 1;
    - trial = partial_rem[WIDTH:0] - {1'b0, divisor} (WIDTH+1 bits);
    - if trial is non-negative, partial_rem=trial and quotient bit=1;
    - otherwise partial_rem is unchanged and quotient bit=0.
  - Quotient bits accumulate into the dividend register's LSB.
  - counter increments each cycle. When counter==WIDTH-1, the final step's quotient/remainder are written into the output registers and next state is DONE.
  - Total: WIDTH CALC cycles. stallreq stays high for WIDTH+1 cycles in all (the IDLE request cycle plus the CALC cycles).
- DONE:
  - stallreq=0, out_valid=1 for exactly one cycle; next state IDLE unconditionally.
  - The pipeline advances on this cycle, so the top samples the result here.
- Output hold: quotient/remainder hold their value until the next completion; they are not cleared on IDLE or flush.
- Back-to-back requests:
  - in_valid high again in the cycle after DONE is a new request and restarts from IDLE.
  - in_valid seen during DONE is ignored.
- flush:
  - In CALC: next state IDLE, stallreq=0 in that same cycle, no out_valid, outputs unchanged.
  - In DONE: no effect (result already delivered).
- Operand changes while `stallreq`=1 are a requester protocol violation. The block computes on the captured values only.
- Arithmetic: the partial remainder is WIDTH+1 bits, so there is no overflow. a < b gives q=0, r=a.

Decomposition:
- Shared package mdu_pkg holds:
  - the state enum (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - DIV_WIDTH=64 and DIV_CNT_W=6;
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module: div_step.
  - Combinational single restoring iteration.
  - Inputs: partial_rem, dividend MSB, divisor.
  - Outputs: next partial_rem, quotient bit.
  - Keeps the FSM/counter file separate from the datapath and allows later unrolling to 2 steps per cycle.

Test Plan:
- a=100, b=7, in_valid held → stallreq high 65 consecutive cycles; next cycle out_valid=1, quotient=14, remainder=2; stallreq=0.
- a=5, b=0 → stallreq high 1 cycle; next cycle out_valid=1, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1 → quotient=a, remainder=0. Then a=3, b=0x8000_0000_0000_0000 → quotient=0, remainder=3. Both take 64 CALC cycles.
- Two requests back-to-back, (a=1000, b=10) then (a=9, b=4) with in_valid re-asserted right after DONE → two out_valid pulses 66 cycles apart carrying q=100/r=0 then q=2/r=1.
- flush asserted in CALC cycle 20 of (a=100, b=7) → stallreq=0 the same cycle, state IDLE, no out_valid, quotient/remainder keep the previous result. A later (a=50, b=5) returns q=10, r=0.
- rst_n pulsed low mid-CALC → all outputs 0 asynchronously, busy=0. After release, (a=7, b=2) gives q=3, r=1.
